tri_span_walker: RTL

TRI_SPAN_WALKER -- requirements
Module: tri_span_walker

---
 rtl/tri_span_walker.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/tri_span_walker.sv
// Triangle scan walker: sorts three vertices by y, then walks the long and short
// edges with integer error accumulators, handing one horizontal span per y to a span filler.
module tri_span_walker (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_1,
    output logic        ack_1,
    input  logic [23:0] v0,
    input  logic [23:0] v1,
    input  logic [23:0] v2,
    input  logic [23:0] rgb_in,
    output logic [23:0] rgb,
    output logic [23:0] point_out_a,
    output logic [23:0] point_out_b,
    output logic        req_2,
    input  logic        ack_2
);

    typedef enum logic [3:0] {
        IDLE, LOAD, SORT1, SORT2, SORT3, INIT, EMIT, RELEASE, STEP, DONE
    } state_t;

    state_t      state_reg, state_next;
    logic [23:0] vtx_reg [3];
    logic [23:0] rgb_reg;
    logic [7:0]  y_reg;

    logic [1:0]  init_en;
    logic [1:0]  add_en;
    logic        step_en;
    logic        y_inc;
    logic [1:0]  pending;
    logic [23:0] edge_start [2];
    logic [23:0] edge_end   [2];
    logic [7:0]  cur_x [2];
    logic [7:0]  cur_z [2];

    logic [7:0]  y0, y1, y2;
    assign y0 = vtx_reg[0][15:8];
    assign y1 = vtx_reg[1][15:8];
    assign y2 = vtx_reg[2][15:8];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= IDLE;
            vtx_reg[0] <= '0;
            vtx_reg[1] <= '0;
            vtx_reg[2] <= '0;
            rgb_reg    <= '0;
            y_reg      <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: if (req_1) begin
                    vtx_reg[0] <= v0;
                    vtx_reg[1] <= v1;
                    vtx_reg[2] <= v2;
                    rgb_reg    <= rgb_in;
                end
                // strict compare keeps equal-y vertices in input order
                SORT1, SORT3: if (y0 > y1) begin
                    vtx_reg[0] <= vtx_reg[1];
                    vtx_reg[1] <= vtx_reg[0];
                end
                SORT2: if (y1 > y2) begin
                    vtx_reg[1] <= vtx_reg[2];
                    vtx_reg[2] <= vtx_reg[1];
                end
                INIT: y_reg <= y0;
                default: if (y_inc) y_reg <= y_reg + 8'd1;
            endcase
        end
    end

    always_comb begin
        state_next = state_reg;
        init_en    = 2'b00;
        add_en     = 2'b00;
        step_en    = 1'b0;
        y_inc      = 1'b0;
        case (state_reg)
            IDLE:    if (req_1) state_next = LOAD;
            LOAD:    state_next = SORT1;
            SORT1:   state_next = SORT2;
            SORT2:   state_next = SORT3;
            SORT3:   state_next = INIT;
            INIT: begin
                init_en    = 2'b11;
                state_next = EMIT;
            end
            EMIT:    if (ack_2) state_next = RELEASE;
            RELEASE: if (!ack_2) begin
                if (y_reg == y2) begin
                    state_next = DONE;
                end else begin
                    state_next = STEP;
                    y_inc      = 1'b1;
                    add_en     = 2'b11;
                    // entering the lower half: short edge swaps to V1->V2
                    if ((y_reg + 8'd1) == y1 && y1 < y2) begin
                        init_en[1] = 1'b1;
                        add_en[1]  = 1'b0;
                    end
                end
            end
            STEP: begin
                step_en = 1'b1;
                if (pending == 2'b00) state_next = EMIT;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Flat triangles use a degenerate short edge sitting on V2.
    always_comb begin
        edge_start[0] = vtx_reg[0];
        edge_end[0]   = vtx_reg[2];
        edge_start[1] = vtx_reg[1];
        edge_end[1]   = vtx_reg[2];
        if (y0 == y2) begin
            edge_start[1] = vtx_reg[2];
        end else if (state_reg == INIT && y0 != y1) begin
            edge_start[1] = vtx_reg[0];
            edge_end[1]   = vtx_reg[1];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_edge
            logic [7:0] x_reg, z_reg, dy_reg, dx_reg, dz_reg;
            logic       x_neg_reg, z_neg_reg;
            logic [9:0] ex_reg, ez_reg;
            logic       x_move, z_move;
            logic [7:0] sx, sz, ex, ez;

            assign sx = edge_start[gi][23:16];
            assign sz = edge_start[gi][7:0];
            assign ex = edge_end[gi][23:16];
            assign ez = edge_end[gi][7:0];

            assign x_move      = (dy_reg != 8'd0) && (ex_reg >= {2'b00, dy_reg});
            assign z_move      = (dy_reg != 8'd0) && (ez_reg >= {2'b00, dy_reg});
            assign pending[gi] = x_move | z_move;
            assign cur_x[gi]   = x_reg;
            assign cur_z[gi]   = z_reg;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    x_reg     <= '0;
                    z_reg     <= '0;
                    dy_reg    <= '0;
                    dx_reg    <= '0;
                    dz_reg    <= '0;
                    x_neg_reg <= 1'b0;
                    z_neg_reg <= 1'b0;
                    ex_reg    <= '0;
                    ez_reg    <= '0;
                end else if (init_en[gi]) begin
                    x_reg     <= sx;
                    z_reg     <= sz;
                    dy_reg    <= edge_end[gi][15:8] - edge_start[gi][15:8];
                    dx_reg    <= (ex > sx) ? ex - sx : sx - ex;
                    dz_reg    <= (ez > sz) ? ez - sz : sz - ez;
                    x_neg_reg <= !(ex > sx);
                    z_neg_reg <= !(ez > sz);
                    ex_reg    <= '0;
                    ez_reg    <= '0;
                end else if (add_en[gi] && dy_reg != 8'd0) begin
                    ex_reg <= ex_reg + {2'b00, dx_reg};
                    ez_reg <= ez_reg + {2'b00, dz_reg};
                end else if (step_en) begin
                    if (x_move) begin
                        x_reg  <= x_neg_reg ? x_reg - 8'd1 : x_reg + 8'd1;
                        ex_reg <= ex_reg - {2'b00, dy_reg};
                    end
                    if (z_move) begin
                        z_reg  <= z_neg_reg ? z_reg - 8'd1 : z_reg + 8'd1;
                        ez_reg <= ez_reg - {2'b00, dy_reg};
                    end
                end
            end
        end
    endgenerate

    assign ack_1       = (state_reg != IDLE) && (state_reg != DONE);
    assign req_2       = (state_reg == EMIT);
    assign rgb         = rgb_reg;
    assign point_out_a = {cur_x[0], y_reg, cur_z[0]};
    assign point_out_b = {cur_x[1], y_reg, cur_z[1]};

endmodule
